// File: rtl/gpu_pkg.sv
// Shared constants and types for the tiny-GPU renderer pipeline.
// Holds the screen geometry, the object-motion limits derived from it,
// the coordinate type and the VS polarity helper.
package gpu_pkg;

    localparam int unsigned H_ACTIVE = 32'd640;
    localparam int unsigned V_ACTIVE = 32'd480;
    localparam int unsigned BORDER   = 32'd10;
    localparam int unsigned OBJ_SIZE = 32'd30;
    localparam int unsigned COORD_W  = 32'd10;

    // Object top-left limits: inside the border, with the whole square visible.
    localparam int unsigned X_MIN_DEF  = BORDER;
    localparam int unsigned X_MAX_DEF  = H_ACTIVE - BORDER - OBJ_SIZE;
    localparam int unsigned Y_MIN_DEF  = BORDER;
    localparam int unsigned Y_MAX_DEF  = V_ACTIVE - BORDER - OBJ_SIZE;
    localparam int unsigned X_INIT_DEF = H_ACTIVE / 32'd2;
    localparam int unsigned Y_INIT_DEF = V_ACTIVE / 32'd2;

    typedef logic [COORD_W-1:0] coord_t;

    // Map a raw VS level to "sync pulse active" for either polarity.
    function automatic logic vs_act(input logic v, input logic active_low);
        logic a;
        if (active_low) begin
            a = ~v;
        end else begin
            a = v;
        end
        return a;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stability
// counter. The debounced level flips only after the synchronised input has
// disagreed with it for 2^DEB_BITS consecutive cycles.
module btn_debounce #(
    parameter int unsigned DEB_BITS = 32'd16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                level_q, level_d;
    logic [DEB_BITS-1:0] cnt_q,   cnt_d;

    // Next state: shift the synchroniser, count disagreement, flip when saturated.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = {DEB_BITS{1'b0}};
        end else if (cnt_q == {DEB_BITS{1'b1}}) begin
            level_d = ~level_q;
            cnt_d   = {DEB_BITS{1'b0}};
        end else begin
            cnt_d = cnt_q + DEB_BITS'(1);
        end
    end

    // State registers; reset discards any debounce progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= {DEB_BITS{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/obj_motion_ctrl.sv
// Object motion controller: debounces four buttons and steps the object
// position once per video frame (start of the VS pulse), keeping it inside
// the screen border.
// Optional build macro OBJ_WRAP_EN: motion past a limit wraps to the
// opposite limit instead of clamping.
module obj_motion_ctrl
    import gpu_pkg::*;
#(
    parameter int unsigned X_INIT        = X_INIT_DEF,
    parameter int unsigned Y_INIT        = Y_INIT_DEF,
    parameter int unsigned X_MIN         = X_MIN_DEF,
    parameter int unsigned X_MAX         = X_MAX_DEF,
    parameter int unsigned Y_MIN         = Y_MIN_DEF,
    parameter int unsigned Y_MAX         = Y_MAX_DEF,
    parameter int unsigned STEP          = 32'd1,   // 1 .. X_MAX-X_MIN
    parameter int unsigned DEB_BITS      = 32'd16,
    parameter bit          VS_ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_up,
    input  logic         btn_dn,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         vs,
    output logic [9:0]   o_x,
    output logic [9:0]   o_y,
    output logic         moved
);

    localparam coord_t     X_MIN_C  = coord_t'(X_MIN);
    localparam coord_t     X_MAX_C  = coord_t'(X_MAX);
    localparam coord_t     Y_MIN_C  = coord_t'(Y_MIN);
    localparam coord_t     Y_MAX_C  = coord_t'(Y_MAX);
    localparam coord_t     STEP_C   = coord_t'(STEP);
    // 11-bit thresholds so the limit tests never wrap or underflow.
    localparam logic [10:0] X_LO_THR = 11'(X_MIN + STEP);
    localparam logic [10:0] X_HI_THR = 11'(X_MAX - STEP);
    localparam logic [10:0] Y_LO_THR = 11'(Y_MIN + STEP);
    localparam logic [10:0] Y_HI_THR = 11'(Y_MAX - STEP);
    localparam logic        VS_IDLE  = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

    // One axis update: dec/inc alone move by STEP, both or neither hold.
    function automatic coord_t axis_next(
        input coord_t      pos,
        input logic        dec,
        input logic        inc,
        input coord_t      lo,
        input coord_t      hi,
        input logic [10:0] lo_thr,
        input logic [10:0] hi_thr
    );
        coord_t      r;
        logic [10:0] pos_w;
        pos_w = {1'b0, pos};
        r     = pos;
        if (dec && !inc) begin
            if (pos_w < lo_thr) begin
`ifdef OBJ_WRAP_EN
                r = hi;
`else
                r = lo;
`endif
            end else begin
                r = pos - STEP_C;
            end
        end else if (inc && !dec) begin
            if (pos_w > hi_thr) begin
`ifdef OBJ_WRAP_EN
                r = lo;
`else
                r = hi;
`endif
            end else begin
                r = pos + STEP_C;
            end
        end else begin
            r = pos;
        end
        return r;
    endfunction

    logic   lvl_up, lvl_dn, lvl_left, lvl_right;
    logic   vs_d1_q, vs_d1_d;
    logic   vs_d2_q, vs_d2_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   moved_q, moved_d;
    logic   evt;

    btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_up (
        .clk(clk), .rst(rst), .raw(btn_up), .level(lvl_up)
    );
    btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_dn (
        .clk(clk), .rst(rst), .raw(btn_dn), .level(lvl_dn)
    );
    btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_left (
        .clk(clk), .rst(rst), .raw(btn_left), .level(lvl_left)
    );
    btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_right (
        .clk(clk), .rst(rst), .raw(btn_right), .level(lvl_right)
    );

    // Frame event: first cycle in which the registered VS is seen active.
    assign evt = vs_act(vs_d1_q, VS_ACTIVE_LOW) & ~vs_act(vs_d2_q, VS_ACTIVE_LOW);

    // Next state: VS history shift and once-per-frame position update.
    always_comb begin
        vs_d1_d = vs;
        vs_d2_d = vs_d1_q;
        x_d     = x_q;
        y_d     = y_q;
        moved_d = 1'b0;
        if (evt) begin
            x_d     = axis_next(x_q, lvl_left, lvl_right, X_MIN_C, X_MAX_C, X_LO_THR, X_HI_THR);
            y_d     = axis_next(y_q, lvl_up,   lvl_dn,    Y_MIN_C, Y_MAX_C, Y_LO_THR, Y_HI_THR);
            moved_d = (x_d != x_q) || (y_d != y_q);
        end else begin
            moved_d = 1'b0;
        end
    end

    // State registers; reset wins over a coincident frame event.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d1_q <= VS_IDLE;
            vs_d2_q <= VS_IDLE;
            x_q     <= coord_t'(X_INIT);
            y_q     <= coord_t'(Y_INIT);
            moved_q <= 1'b0;
        end else begin
            vs_d1_q <= vs_d1_d;
            vs_d2_q <= vs_d2_d;
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
        end
    end

    assign o_x   = x_q;
    assign o_y   = y_q;
    assign moved = moved_q;

endmodule

// File: tb/tb_obj_motion_ctrl.sv
// Self-checking bench for obj_motion_ctrl with a 16-cycle debounce.
// A behavioural model tracks the expected position from the button history
// and VS pulses; directed steps add absolute checks at key points.
module tb_obj_motion_ctrl;

    localparam int DEB  = 4;
    localparam int WIN  = 1 << DEB;
    localparam int HIST = WIN + 2;

    logic       clk = 1'b0;
    logic       rst, btn_up, btn_dn, btn_left, btn_right, vs;
    logic       b2_up, b2_left;
    logic [9:0] o_x, o_y, o2_x, o2_y;
    logic       moved, moved2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obj_motion_ctrl #(.DEB_BITS(DEB)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .btn_left(btn_left), .btn_right(btn_right), .vs(vs),
        .o_x(o_x), .o_y(o_y), .moved(moved)
    );

    obj_motion_ctrl #(.DEB_BITS(DEB), .STEP(3), .X_INIT(12), .Y_INIT(12)) dut2 (
        .clk(clk), .rst(rst), .btn_up(b2_up), .btn_dn(1'b0),
        .btn_left(b2_left), .btn_right(1'b0), .vs(vs),
        .o_x(o2_x), .o_y(o2_y), .moved(moved2)
    );

    // ---------------- reference model ----------------
    int         mx, my;
    bit         mmoved;
    bit [3:0]   lvl;
    bit [HIST-1:0] hist [4];
    bit         vp1, vp2;
    bit         chk_en = 1'b0;

    function automatic int m_axis(int p, bit dec, bit inc, int lo, int hi, int st);
        if (dec && !inc) begin
`ifdef OBJ_WRAP_EN
            if (p - st < lo) return hi;
`else
            if (p - st < lo) return lo;
`endif
            return p - st;
        end
        if (inc && !dec) begin
`ifdef OBJ_WRAP_EN
            if (p + st > hi) return lo;
`else
            if (p + st > hi) return hi;
`endif
            return p + st;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        bit [3:0] raw;
        int nx, ny;
        raw = {btn_right, btn_left, btn_dn, btn_up};
        if (rst) begin
            mx = 320; my = 240; mmoved = 1'b0; lvl = 4'b0000;
            vp1 = 1'b1; vp2 = 1'b1;
            for (int b = 0; b < 4; b++) hist[b] = '0;
        end else begin
            // frame start: VS low now (one edge ago), high the edge before
            if (!vp1 && vp2) begin
                nx = m_axis(mx, lvl[2], lvl[3], 10, 600, 1);
                ny = m_axis(my, lvl[0], lvl[1], 10, 440, 1);
                mmoved = (nx != mx) || (ny != my);
                mx = nx; my = ny;
            end else begin
                mmoved = 1'b0;
            end
            vp2 = vp1; vp1 = vs;
            // a level is accepted once WIN consecutive samples (ending two edges ago) disagree with it
            for (int b = 0; b < 4; b++) begin
                hist[b] = {hist[b][HIST-2:0], raw[b]};
                if (hist[b][HIST-1:2] == {WIN{~lvl[b]}}) lvl[b] = ~lvl[b];
            end
        end
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // continuous comparison of the primary instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check(32'(o_x),   32'(mx),     "model_x");
            check(32'(o_y),   32'(my),     "model_y");
            check(32'(moved), 32'(mmoved), "model_moved");
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves the caller at the negedge just after the frame-event edge
    task automatic frame_start();
        vs = 1'b0;
        cyc(2);
    endtask

    task automatic frame_end();
        cyc(2);
        vs = 1'b1;
        cyc(8);
    endtask

    task automatic frame();
        frame_start();
        frame_end();
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1;
        btn_up = 1'b0; btn_dn = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        b2_up = 1'b0; b2_left = 1'b0;

        // reset
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        check(32'(o_x), 32'd320, "rst_x");
        check(32'(o_y), 32'd240, "rst_y");
        check(32'(moved), 32'd0, "rst_moved");
        check(32'(o2_x), 32'd12, "rst2_x");
        check(32'(o2_y), 32'd12, "rst2_y");
        rst = 1'b0;

        // held button without frames: no motion
        btn_right = 1'b1;
        cyc(1000);
        check(32'(o_x), 32'd320, "no_vs_x");
        btn_right = 1'b0;
        cyc(25);

        // glitch shorter than the debounce window
        btn_right = 1'b1;
        cyc(10);
        btn_right = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(190);
            frame_start();
            check(32'(o_x), 32'd320, "glitch_x");
            check(32'(moved), 32'd0, "glitch_moved");
            frame_end();
        end

        // right steps, one per frame
        btn_right = 1'b1;
        cyc(20);
        for (int i = 1; i <= 5; i++) begin
            frame_start();
            check(32'(o_x), 32'(320 + i), "step_x");
            check(32'(o_y), 32'd240, "step_y");
            check(32'(moved), 32'd1, "step_moved");
            frame_end();
        end

        // conflicting up+dn holds y while x still moves
        btn_up = 1'b1; btn_dn = 1'b1;
        cyc(20);
        frame_start();
        check(32'(o_x), 32'd326, "conflict_x");
        check(32'(o_y), 32'd240, "conflict_y");
        check(32'(moved), 32'd1, "conflict_moved");
        frame_end();
        btn_up = 1'b0; btn_dn = 1'b0; btn_right = 1'b0;
        cyc(20);

        // diagonal with STEP=3 from (12,12) clamps both axes to (10,10)
        b2_up = 1'b1; b2_left = 1'b1;
        cyc(20);
        frame_start();
        check(32'(o2_x), 32'd10, "diag_x");
        check(32'(o2_y), 32'd10, "diag_y");
        check(32'(moved2), 32'd1, "diag_moved");
        frame_end();
        b2_up = 1'b0; b2_left = 1'b0;
        cyc(20);

        // drive to the right limit, then one frame past it
        btn_right = 1'b1;
        cyc(20);
        for (int i = 0; i < 400 && mx != 600; i++) frame();
        check(32'(o_x), 32'd600, "limit_x");
        frame_start();
`ifdef OBJ_WRAP_EN
        check(32'(o_x), 32'd10, "wrap_x");
        check(32'(moved), 32'd1, "wrap_moved");
`else
        check(32'(o_x), 32'd600, "clamp_x");
        check(32'(moved), 32'd0, "clamp_moved");
`endif
        frame_end();
        btn_right = 1'b0;
        cyc(20);

        // reset mid-debounce, coincident with a frame event
        btn_right = 1'b1;
        cyc(8);
        vs = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check(32'(o_x), 32'd320, "midrst_x");
        check(32'(o_y), 32'd240, "midrst_y");
        check(32'(moved), 32'd0, "midrst_moved");
        rst = 1'b0;
        cyc(2);
        check(32'(o_x), 32'd320, "postrst_x");
        vs = 1'b1;
        cyc(2);
        vs = 1'b0;
        cyc(2);
        check(32'(o_x), 32'd320, "redeb_x");
        check(32'(moved), 32'd0, "redeb_moved");
        vs = 1'b1;
        cyc(20);
        frame_start();
        check(32'(o_x), 32'd321, "redeb_done_x");
        check(32'(moved), 32'd1, "redeb_done_moved");
        frame_end();

        // randomized buttons, frame timing and occasional resets
        for (int i = 0; i < 60; i++) begin
            {btn_up, btn_dn, btn_left, btn_right} = 4'($urandom);
            cyc($urandom_range(3, 40));
            if ($urandom_range(0, 1) == 1) frame();
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
        end

        cyc(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
